pri_enc_scan: RTL and testbench

PRI_ENC_SCAN -- requirements
Module: pri_enc_scan

---
 rtl/pri_enc_pkg.sv | 19 +
 rtl/pri_enc_comb.sv | 47 ++++
 rtl/pri_enc_scan.sv | 146 ++++++++++++++
 tb/tb_pri_enc_scan.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pri_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pri_enc_pkg                                                     |
// | Purpose  : Shared types and constants for the pri_enc_scan block.          |
// |            Holds the scan FSM state enum and the default request width.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pri_enc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : pri_enc_pkg
`default_nettype wire

// File: rtl/pri_enc_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pri_enc_comb                                                    |
// | Purpose  : Purely combinational priority encoder. Returns the index of the |
// |            highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of vec,   |
// |            plus a flag telling whether any bit is set.                     |
// | Ports    : vec [WIDTH] in  - request vector                                |
// |            idx [IDXW]  out - priority index (0 when vec is all-zero)       |
// |            any         out - at least one bit of vec is set                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pri_enc_comb
  import pri_enc_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  assign any = |vec;

  // The loop lets the last matching bit win, so the walk direction is chosen
  // opposite to the priority direction.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (vec[i]) idx = IDXW'(i);
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (vec[i]) idx = IDXW'(i);
        end
      end
    end
  endgenerate

endmodule : pri_enc_comb
`default_nettype wire

// File: rtl/pri_enc_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pri_enc_scan                                                    |
// | Purpose  : Accepts a request vector and emits the indices of its set bits  |
// |            one beat at a time in priority order over a valid/ready stream. |
// |            An all-zero vector yields a single beat flagged by out_zero.    |
// | Ports    : clk, rst_n (sync, active-low), en (accept enable),             |
// |            flush (sync scan abort),                                        |
// |            in_valid/in_ready/bin_in [WIDTH]  - vector input handshake      |
// |            out_valid/out_ready/bin_out [IDXW]/out_last/out_zero - beats    |
// |            out_cnt [IDXW+1] - beat ordinal (only with PRI_ENC_SCAN_CNT_EN) |
// | Config   : define PRI_ENC_SCAN_CNT_EN to add the out_cnt beat counter.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pri_enc_scan
  import pri_enc_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  bin_out,
  output logic             out_last,
`ifdef PRI_ENC_SCAN_CNT_EN
  output logic [IDXW:0]    out_cnt,
`endif
  output logic             out_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;

  logic [IDXW-1:0]  pri_idx;
  logic             pri_any;
  logic             single_bit;
  logic             accept;
  logic             beat;

  pri_enc_comb #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_pri_enc_comb (
    .vec (vec_q),
    .idx (pri_idx),
    .any (pri_any)
  );

  // Clearing the lowest set bit leaves zero only when at most one bit is set.
  assign single_bit = ~|(vec_q & (vec_q - WIDTH'(1)));

  // in_ready is qualified with rst_n so it reads 0 for the whole reset window.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    bin_out   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    if (state_q == IDLE) begin
      in_ready = rst_n & en & ~flush;
    end else begin
      out_valid = 1'b1;
      bin_out   = pri_idx;
      out_last  = single_bit;
      // vec can only be empty during SCAN if the accepted vector was empty,
      // since the last real bit returns the FSM to IDLE.
      out_zero  = ~pri_any;
    end
  end

  assign accept = in_valid & in_ready;
  assign beat   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    if (flush) begin
      state_d = IDLE;
      vec_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SCAN;
            vec_d   = bin_in;
          end
        end
        SCAN: begin
          if (beat) begin
            vec_d = vec_q & ~(WIDTH'(1) << pri_idx);
            if (single_bit) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          vec_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

`ifdef PRI_ENC_SCAN_CNT_EN
  logic [IDXW:0] cnt_q, cnt_d;

  // Counts beats already emitted for the current vector; restarts at the
  // last beat so IDLE always shows 0.
  always_comb begin
    cnt_d = cnt_q;
    if (flush || accept) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = single_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule : pri_enc_scan
`default_nettype wire

// File: tb/tb_pri_enc_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pri_enc_scan                                                 |
// | Purpose  : Directed self-checking bench for pri_enc_scan. Two instances    |
// |            (MSB_FIRST=1 and MSB_FIRST=0) share all inputs.                 |
// | Config   : honours PRI_ENC_SCAN_CNT_EN for the out_cnt checks.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pri_enc_scan;

  localparam int WIDTH = 16;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, flush, in_valid, out_ready;
  logic [WIDTH-1:0] bin_in;

  logic             m_in_ready, m_out_valid, m_out_last, m_out_zero;
  logic [IDXW-1:0]  m_bin_out;
  logic             l_in_ready, l_out_valid, l_out_last, l_out_zero;
  logic [IDXW-1:0]  l_bin_out;
`ifdef PRI_ENC_SCAN_CNT_EN
  logic [IDXW:0]    m_out_cnt, l_out_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_enc_scan #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(m_in_ready), .bin_in(bin_in),
    .out_valid(m_out_valid), .out_ready(out_ready), .bin_out(m_bin_out),
    .out_last(m_out_last),
`ifdef PRI_ENC_SCAN_CNT_EN
    .out_cnt(m_out_cnt),
`endif
    .out_zero(m_out_zero)
  );

  pri_enc_scan #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(l_in_ready), .bin_in(bin_in),
    .out_valid(l_out_valid), .out_ready(out_ready), .bin_out(l_bin_out),
    .out_last(l_out_last),
`ifdef PRI_ENC_SCAN_CNT_EN
    .out_cnt(l_out_cnt),
`endif
    .out_zero(l_out_zero)
  );

  // Advance one clock; inputs change and outputs are sampled 2ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1; bin_in = 16'h8421;
    cyc(); cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", m_out_valid); end
    checks++; if (m_bin_out !== 4'd0) begin errors++; $display("FAIL rst_bin_out: got %0d expected 0", m_bin_out); end
    checks++; if (m_out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", m_out_last); end
    checks++; if (m_out_zero !== 1'b0) begin errors++; $display("FAIL rst_out_zero: got %b expected 0", m_out_zero); end
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", m_in_ready); end
`ifdef PRI_ENC_SCAN_CNT_EN
    checks++; if (m_out_cnt !== 5'd0) begin errors++; $display("FAIL rst_out_cnt: got %0d expected 0", m_out_cnt); end
`endif
    in_valid = 1'b0; rst_n = 1'b1;
    cyc(); #1;
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", m_in_ready); end
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b expected 0", m_out_valid); end
  endtask

  // 16'h8421 with out_ready high: MSB instance 15,10,5,0; LSB instance 0,5,10,15.
  task automatic test_msb_scan();
    logic [3:0] exp_m [4];
    logic [3:0] exp_l [4];
    exp_m = '{4'd15, 4'd10, 4'd5, 4'd0};
    exp_l = '{4'd0, 4'd5, 4'd10, 4'd15};
    in_valid = 1'b1; bin_in = 16'h8421; out_ready = 1'b1;
    #1;
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL scan_accept_ready: got %b expected 1", m_in_ready); end
    cyc();
    // Leave in_valid high to show nothing is re-accepted on the last beat.
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL scan_valid[%0d]: got %b expected 1", k, m_out_valid); end
      checks++; if (m_bin_out !== exp_m[k]) begin errors++; $display("FAIL scan_msb_idx[%0d]: got %0d expected %0d", k, m_bin_out, exp_m[k]); end
      checks++; if (l_bin_out !== exp_l[k]) begin errors++; $display("FAIL scan_lsb_idx[%0d]: got %0d expected %0d", k, l_bin_out, exp_l[k]); end
      checks++; if (m_out_last !== (k == 3)) begin errors++; $display("FAIL scan_last[%0d]: got %b expected %b", k, m_out_last, (k == 3)); end
      checks++; if (m_out_zero !== 1'b0) begin errors++; $display("FAIL scan_zero[%0d]: got %b expected 0", k, m_out_zero); end
      checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL scan_in_ready[%0d]: got %b expected 0", k, m_in_ready); end
`ifdef PRI_ENC_SCAN_CNT_EN
      checks++; if (m_out_cnt !== 5'(k)) begin errors++; $display("FAIL scan_cnt[%0d]: got %0d expected %0d", k, m_out_cnt, k); end
`endif
      if (k == 3) in_valid = 1'b0;
      cyc();
    end
    #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL scan_done_valid: got %b expected 0", m_out_valid); end
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL scan_done_ready: got %b expected 1", m_in_ready); end
  endtask

  // LSB-first scan of 16'h8421, stalled three cycles on beat 5.
  task automatic test_lsb_stall();
    in_valid = 1'b1; bin_in = 16'h8421; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (l_bin_out !== 4'd0) begin errors++; $display("FAIL stall_first: got %0d expected 0", l_bin_out); end
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (l_bin_out !== 4'd5) begin errors++; $display("FAIL stall_hold[%0d]: got %0d expected 5", k, l_bin_out); end
      checks++; if (l_out_valid !== 1'b1 || l_out_last !== 1'b0 || l_out_zero !== 1'b0) begin
        errors++; $display("FAIL stall_flags[%0d]: got v%b l%b z%b expected v1 l0 z0", k, l_out_valid, l_out_last, l_out_zero);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (l_bin_out !== 4'd5) begin errors++; $display("FAIL stall_release: got %0d expected 5", l_bin_out); end
    cyc(); #1;
    checks++; if (l_bin_out !== 4'd10) begin errors++; $display("FAIL stall_next: got %0d expected 10", l_bin_out); end
    cyc(); #1;
    checks++; if (l_bin_out !== 4'd15 || l_out_last !== 1'b1) begin errors++; $display("FAIL stall_final: got %0d last %b expected 15 last 1", l_bin_out, l_out_last); end
    cyc(); #1;
    checks++; if (l_out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", l_out_valid); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; bin_in = 16'h0000; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", m_out_valid); end
    checks++; if (m_bin_out !== 4'd0 || l_bin_out !== 4'd0) begin errors++; $display("FAIL zero_idx: got %0d/%0d expected 0/0", m_bin_out, l_bin_out); end
    checks++; if (m_out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag: got %b expected 1", m_out_zero); end
    checks++; if (m_out_last !== 1'b1) begin errors++; $display("FAIL zero_last: got %b expected 1", m_out_last); end
    cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL zero_single_beat: got %b expected 0", m_out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; bin_in = 16'hFFFF; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc(); #1;
    checks++; if (m_bin_out !== 4'd13) begin errors++; $display("FAIL flush_beat13: got %0d expected 13", m_bin_out); end
    cyc();
    flush = 1'b1;
    cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", m_out_valid); end
    // Flush held in IDLE blocks acceptance even with a valid vector offered.
    in_valid = 1'b1; bin_in = 16'h0002;
    #1;
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b expected 0", m_in_ready); end
    cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_wins_accept: got %b expected 0", m_out_valid); end
    flush = 1'b0;
    #1;
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL flush_release_ready: got %b expected 1", m_in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (m_bin_out !== 4'd1 || m_out_last !== 1'b1 || m_out_zero !== 1'b0) begin
      errors++; $display("FAIL flush_next_vec: got idx %0d last %b zero %b expected idx 1 last 1 zero 0", m_bin_out, m_out_last, m_out_zero);
    end
`ifdef PRI_ENC_SCAN_CNT_EN
    checks++; if (m_out_cnt !== 5'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", m_out_cnt); end
`endif
    cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_done: got %b expected 0", m_out_valid); end
  endtask

  task automatic test_en_and_reset();
    en = 1'b0; in_valid = 1'b1; bin_in = 16'h00F0; out_ready = 1'b1;
    #1;
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL en_low_ready: got %b expected 0", m_in_ready); end
    cyc(); cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL en_low_no_beat: got %b expected 0", m_out_valid); end
    en = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (m_bin_out !== 4'd7) begin errors++; $display("FAIL en_first_beat: got %0d expected 7", m_bin_out); end
    en = 1'b0;
    cyc(); #1;
    checks++; if (m_bin_out !== 4'd6 || m_out_valid !== 1'b1) begin errors++; $display("FAIL en_low_scan: got %0d v%b expected 6 v1", m_bin_out, m_out_valid); end
    en = 1'b1;
    rst_n = 1'b0;
    cyc(); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", m_out_valid); end
    checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", m_in_ready); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_beat[%0d]: got %b expected 0", k, m_out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_scan();
    test_lsb_stall();
    test_zero();
    test_flush();
    test_en_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_pri_enc_scan
`default_nettype wire
